calc_pipe: RTL and testbench
============================

CALC_PIPE -- requirements
Module: calc_pipe

Interface
REQ-001 The block SHALL have parameter OUT_DEPTH, default 4, giving the output FIFO depth in entries (power of two, minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have ports in_a and in_b, input, 3 bits each: unsigned operands.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the FIFO head holds a result.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head result.
REQ-009 The block SHALL have port out_res, output, 7 bits: the packed result {diff[2:0], sum[3:0]}.
REQ-010 The block SHALL have port out_lt, output, 1 bit: the less-than flag.

Function
REQ-011 The input handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1; only then are in_a and in_b sampled.
REQ-012 sum SHALL be in_a + in_b computed at 4 bits, with no overflow possible (maximum 14).
REQ-013 diff SHALL be in_a - in_b truncated to 3 bits, wrapping modulo 8.
REQ-014 out_lt SHALL equal diff[2], the sign of the 3-bit wrapped difference; for example a=2, b=3 gives lt=1, and a=0, b=7 gives diff=1, lt=0.
REQ-015 The datapath SHALL have two register stages: S1 holds the captured operands plus a valid bit; S2 holds the computed {diff, sum, lt} plus a valid bit.
REQ-016 S2 SHALL write into the output FIFO on the edge after it becomes valid.
REQ-017 Pipeline stages SHALL always advance and never stall; backpressure is applied only through in_ready.
REQ-018 in_ready SHALL be 1 when fifo_count + S1.valid + S2.valid < OUT_DEPTH; this credit rule guarantees the FIFO never overflows.
REQ-019 Latency SHALL be: operands accepted at edge N, out_valid=1 with the matching result after edge N+2, provided the FIFO was empty.
REQ-020 Sustained throughput SHALL be one result per clock while out_ready=1.
REQ-021 The output handshake SHALL occur on an edge where out_valid=1 and out_ready=1; the FIFO head then pops.
REQ-022 Push and pop on the same edge SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-023 Results SHALL leave the block in strict acceptance order.
REQ-024 Read and write pointers SHALL wrap modulo OUT_DEPTH.
REQ-025 When the FIFO is empty, out_valid SHALL be 0; when it is full, in_ready SHALL be 0.
REQ-026 out_res and out_lt SHALL always show the FIFO head; their value is don't-care while out_valid=0.
REQ-027 in_ready SHALL be a function of registered state only, with no combinational path from out_ready.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear the S1 and S2 valid bits, fifo_count and both pointers.
REQ-029 During reset, outputs SHALL be: in_ready=0, out_valid=0, out_res=7'h00, out_lt=0.
REQ-030 On the first edge after rst_n deasserts, in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and buffered results; none are emitted after reset.

Configuration
REQ-032 When CALC_PIPE_STATS_EN is defined, the block SHALL add an output port txn_cnt, 16 bits.
REQ-033 txn_cnt SHALL increment once per output handshake, saturate at 16'hFFFF, and reset to 0.
REQ-034 When CALC_PIPE_STATS_EN is undefined, the txn_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Single transfer: a=2, b=1 with out_ready=1 -> out_valid 2 edges after acceptance, out_res=7'h13, out_lt=0.
REQ-036 Negative difference: a=2, b=3 -> out_res=7'h75, out_lt=1; a=0, b=7 -> out_res=7'h17, out_lt=0; a=7, b=7 -> out_res=7'h0E, out_lt=0.
REQ-037 Backpressure: out_ready=0 with continuous in_valid -> exactly OUT_DEPTH pairs accepted, then in_ready=0; release out_ready -> all OUT_DEPTH results emerge in order and no pair is lost.
REQ-038 Full with simultaneous push and pop: FIFO full, out_ready=1 with S2 valid -> count stays at OUT_DEPTH, order preserved, one result per cycle.
REQ-039 Reset mid-stream: pull rst_n low with 3 results buffered -> out_valid=0 immediately; after release, no stale results appear and in_ready=1.
REQ-040 Stats (macro defined): 70000 output handshakes -> txn_cnt=16'hFFFF, held; after reset -> txn_cnt=0.

Source files
------------

// File: rtl/calc_pipe.sv
// calc_pipe: two-stage add/subtract pipeline feeding a credit-controlled output FIFO.
// Defining CALC_PIPE_STATS_EN adds a saturating output-handshake counter on txn_cnt.
module calc_pipe #(
    parameter int OUT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_res,
    output logic       out_lt
`ifdef CALC_PIPE_STATS_EN
    ,
    output logic [15:0] txn_cnt
`endif
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(OUT_DEPTH);

    typedef struct packed {
        logic [2:0] diff;
        logic [3:0] sum;
        logic       lt;
    } result_t;

    logic             ready_en;
    logic             s1_valid;
    logic [2:0]       s1_a;
    logic [2:0]       s1_b;
    logic             s2_valid;
    result_t          s2_res;
    result_t          s1_calc;
    logic [2:0]       diff_c;
    logic [3:0]       sum_c;

    result_t          mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W:0]   credit_used;
    result_t          head;

    logic accept;
    logic push;
    logic pop;

    assign diff_c  = s1_a - s1_b;
    assign sum_c   = {1'b0, s1_a} + {1'b0, s1_b};
    assign s1_calc = {diff_c, sum_c, diff_c[2]};

    // Every accepted pair owns a FIFO slot from acceptance on, so the FIFO can never overflow.
    assign credit_used = {1'b0, fifo_count}
                       + {{CNT_W{1'b0}}, s1_valid}
                       + {{CNT_W{1'b0}}, s2_valid};
    assign in_ready    = ready_en && (credit_used < DEPTH_L);

    assign accept    = in_valid && in_ready;
    assign push      = s2_valid;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            ready_en   <= 1'b1;
            s1_valid   <= accept;
            s2_valid   <= s1_valid;
            fifo_count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: payload and FIFO storage are not reset; the valid bits and fifo_count qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a <= in_a;
            s1_b <= in_b;
        end
        s2_res <= s1_calc;
        if (push) mem[wr_ptr] <= s2_res;
    end

    assign head    = mem[rd_ptr];
    assign out_res = out_valid ? {head.diff, head.sum} : 7'h00;
    assign out_lt  = out_valid & head.lt;

`ifdef CALC_PIPE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt <= 16'h0000;
        end else if (pop && (txn_cnt != 16'hFFFF)) begin
            txn_cnt <= txn_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_calc_pipe.sv
// tb_calc_pipe: directed and random stimulus for calc_pipe, checked against a
// transaction-level model (queue of pending results with their visibility cycle).
module tb_calc_pipe;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_res;
    logic       out_lt;
`ifdef CALC_PIPE_STATS_EN
    logic [15:0] txn_cnt;
`endif

    calc_pipe #(.OUT_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_lt    (out_lt)
`ifdef CALC_PIPE_STATS_EN
        ,
        .txn_cnt   (txn_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int res;
        int lt;
        int vis;
    } exp_t;

    exp_t q[$];
    int   cyc;
    bit   ready_en_m;
    int   txn_m;
    int   passed;
    int   total;

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   diff;
        diff  = (a - b + 8) % 8;
        e.res = diff * 16 + (a + b);
        e.lt  = (diff >= 4) ? 1 : 0;
        e.vis = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        bit exp_ready;
        bit exp_valid;
        exp_ready = ready_en_m && (q.size() < DEPTH);
        exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_res", 32'(out_res), 32'(q[0].res));
            check("out_lt", 32'(out_lt), 32'(q[0].lt));
        end
`ifdef CALC_PIPE_STATS_EN
        check("txn_cnt", 32'(txn_cnt), 32'(txn_m));
`endif
    endtask

    task automatic step(input logic v, input int a, input int b, input logic rdy);
        bit   acc;
        bit   pop;
        exp_t e;
        in_valid  = v;
        in_a      = 3'(a);
        in_b      = 3'(b);
        out_ready = rdy;
        acc = v && ready_en_m && (q.size() < DEPTH);
        pop = rdy && (q.size() > 0) && (q[0].vis <= cyc);
        @(posedge clk);
        cyc++;
        ready_en_m = 1'b1;
        if (pop) begin
            e = q.pop_front();
            if (txn_m < 65535) txn_m++;
        end
        if (acc) begin
            e     = model(a, b);
            e.vis = cyc + 2;
            q.push_back(e);
        end
        #1;
        check_outputs();
    endtask

    task automatic rand_step(input logic v, input logic rdy);
        step(v, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), rdy);
    endtask

    task automatic model_reset();
        q.delete();
        ready_en_m = 1'b0;
        txn_m      = 0;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 3'd0;
        in_b      = 3'd0;
        out_ready = 1'b0;
        model_reset();

        // Reset values while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'h00);
        check("rst_out_lt", 32'(out_lt), 32'd0);
        rst_n = 1'b1;

        // First edge after release raises in_ready
        step(1'b0, 0, 0, 1'b1);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Single transfer: result visible two edges after acceptance
        step(1'b1, 2, 1, 1'b1);
        step(1'b0, 0, 0, 1'b1);
        check("single_early", 32'(out_valid), 32'd0);
        step(1'b0, 0, 0, 1'b1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_res", 32'(out_res), 32'h13);
        check("single_lt", 32'(out_lt), 32'd0);

        // Wrapped differences, back to back
        step(1'b1, 2, 3, 1'b1);
        step(1'b1, 0, 7, 1'b1);
        step(1'b1, 7, 7, 1'b1);
        check("neg_res", 32'(out_res), 32'h75);
        check("neg_lt", 32'(out_lt), 32'd1);
        step(1'b0, 0, 0, 1'b1);
        check("wrap_res", 32'(out_res), 32'h17);
        check("wrap_lt", 32'(out_lt), 32'd0);
        step(1'b0, 0, 0, 1'b1);
        check("max_res", 32'(out_res), 32'h0E);
        check("max_lt", 32'(out_lt), 32'd0);
        repeat (3) step(1'b0, 0, 0, 1'b1);

        // Backpressure: only DEPTH pairs accepted, then drain in order
        repeat (DEPTH + 3) rand_step(1'b1, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (DEPTH + 2) step(1'b0, 0, 0, 1'b1);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Full FIFO with continuous push and pop
        repeat (DEPTH + 3) rand_step(1'b1, 1'b0);
        repeat (16) rand_step(1'b1, 1'b1);
        check("full_stream_valid", 32'(out_valid), 32'd1);
        repeat (DEPTH + 3) step(1'b0, 0, 0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end
        repeat (DEPTH + 3) step(1'b0, 0, 0, 1'b1);

        // Reset with three results buffered
        repeat (3) rand_step(1'b1, 1'b0);
        repeat (2) step(1'b0, 0, 0, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_res", 32'(out_res), 32'h00);
        check("midrst_out_lt", 32'(out_lt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 0, 0, 1'b1);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        repeat (4) step(1'b0, 0, 0, 1'b1);
        check("no_stale", 32'(out_valid), 32'd0);
        repeat (20) rand_step(1'b1, 1'b1);
        repeat (DEPTH + 3) step(1'b0, 0, 0, 1'b1);

`ifdef CALC_PIPE_STATS_EN
        // Handshake counter saturates and holds, then clears on reset
        repeat (70000) rand_step(1'b1, 1'b1);
        check("txn_sat", 32'(txn_cnt), 32'hFFFF);
        repeat (5) rand_step(1'b1, 1'b1);
        check("txn_hold", 32'(txn_cnt), 32'hFFFF);
        rst_n = 1'b0;
        #1;
        check("txn_rst", 32'(txn_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 0, 0, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
